// File: rtl/bt656_line_fetch_ctrl.sv
// BT656 line fetch controller: owns the encoder enable/format, prefetches each
// active line by burst into a ping-pong buffer and streams it under DATA_RQ.
module bt656_line_fetch_ctrl #(
   parameter int LINE_BYTES = 1440,
   parameter int MEM_AW     = 22
) (
   input  logic              CLK_i,
   input  logic              RST,
   input  logic              EN_REQ_i,
   input  logic              PAL_REQ_i,
   input  logic [MEM_AW-1:0] BASE_ADDR_i,
   output logic              BT_EN_o,
   output logic              PAL_o,
   input  logic [9:0]        LINE_CNT_i,
   input  logic [10:0]       PIX_CNT_i,
   input  logic              IM_END_i,
   input  logic              DATA_RQ_i,
   input  logic              FID_i,
   output logic [7:0]        DIN_o,
   output logic              MEM_REQ_o,
   output logic [MEM_AW-1:0] MEM_ADDR_o,
   input  logic              MEM_GNT_i,
   input  logic              MEM_DVAL_i,
   input  logic [7:0]        MEM_DATA_i,
   output logic              UNDERRUN_o
);

   localparam int BW = $clog2(LINE_BYTES);
   localparam logic [BW-1:0]     LAST_IDX = BW'(LINE_BYTES - 1);
   localparam logic [MEM_AW-1:0] LB_A     = MEM_AW'(LINE_BYTES);
   localparam logic [MEM_AW-1:0] STEP2    = MEM_AW'(2 * LINE_BYTES);

   typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic              bt_en_q, bt_en_d;
   logic              pal_q, pal_d;
   logic [7:0]        din_q, din_d;
   logic              mem_req_q, mem_req_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic              und_q, und_d;
   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic              burst_act_q, burst_act_d;
   logic              discard_q, discard_d;
   logic [BW-1:0]     wcnt_q, wcnt_d;
   logic [BW-1:0]     rcnt_q, rcnt_d;
   logic              rq_q, rq_d;
   logic              svalid_q, svalid_d;
   logic [8:0]        field_line_q, field_line_d;
   logic              fld_q, fld_d;
   logic              fld_ok_q, fld_ok_d;
   logic [MEM_AW-1:0] next_addr_q, next_addr_d;

   logic [7:0] buf_mem [2][LINE_BYTES];

   logic          field_start, drain_end, flush, fetch_go, last_beat;
   logic          rq_rise, rq_fall, line_ok, wr_en;
   logic [BW-1:0] rd_idx;
   logic [9:0]    fs2_line;
   logic [8:0]    limit;

   // Next-state logic for the FSM, the fetch engine and the streaming side.
   always_comb begin
      state_d      = state_q;
      bt_en_d      = bt_en_q;
      pal_d        = pal_q;
      din_d        = din_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      und_d        = und_q;
      full_d       = full_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      burst_act_d  = burst_act_q;
      discard_d    = discard_q;
      wcnt_d       = wcnt_q;
      rcnt_d       = rcnt_q;
      rq_d         = DATA_RQ_i;
      svalid_d     = svalid_q;
      field_line_d = field_line_q;
      fld_d        = fld_q;
      fld_ok_d     = fld_ok_q;
      next_addr_d  = next_addr_q;

      fs2_line    = pal_q ? 10'd334 : 10'd284;
      field_start = bt_en_q && (PIX_CNT_i == 11'd0) &&
                    ((LINE_CNT_i == 10'd21) || (LINE_CNT_i == fs2_line));
      drain_end   = (state_q == S_DRAIN) && IM_END_i;
      flush       = field_start || drain_end;
      limit       = pal_q ? 9'd289 : (fld_q ? 9'd240 : 9'd241);
      fetch_go    = (state_q == S_RUN) && fld_ok_q && !mem_req_q && !burst_act_q &&
                    !full_q[wr_bank_q] && (field_line_q < limit) && !field_start;
      last_beat   = (wcnt_q == LAST_IDX);
      wr_en       = burst_act_q && MEM_DVAL_i && !discard_q;
      rq_rise     = DATA_RQ_i && !rq_q;
      rq_fall     = !DATA_RQ_i && rq_q;
      rd_idx      = rq_rise ? '0 : rcnt_q;
      line_ok     = (state_q == S_RUN) && (rq_rise ? full_q[rd_bank_q] : svalid_q);

      case (state_q)
         S_OFF: begin
            if (EN_REQ_i) begin
               bt_en_d = 1'b1;
               pal_d   = PAL_REQ_i;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (IM_END_i) pal_d = PAL_REQ_i;
            if (!EN_REQ_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (IM_END_i) begin
               bt_en_d = 1'b0;
               state_d = S_OFF;
            end
         end
         default: state_d = S_OFF;
      endcase

      if (fetch_go) begin
         mem_req_d  = 1'b1;
         mem_addr_d = next_addr_q;
      end
      if (mem_req_q && MEM_GNT_i) begin
         mem_req_d   = 1'b0;
         burst_act_d = 1'b1;
         wcnt_d      = '0;
      end
      if (burst_act_q && MEM_DVAL_i) begin
         wcnt_d = wcnt_q + BW'(1);
         if (last_beat) begin
            burst_act_d = 1'b0;
            discard_d   = 1'b0;
            if (!discard_q) begin
               full_d[wr_bank_q] = 1'b1;
               field_line_d      = field_line_q + 9'd1;
               next_addr_d       = next_addr_q + STEP2;
               wr_bank_d         = ~wr_bank_q;
            end
         end
      end

      if (DATA_RQ_i) begin
         rcnt_d = rd_idx + BW'(1);
         din_d  = line_ok ? buf_mem[rd_bank_q][rd_idx] : (rd_idx[0] ? 8'h10 : 8'h80);
      end else begin
         din_d = 8'h10;
      end
      if (rq_rise) begin
         svalid_d = line_ok;
         if ((state_q == S_RUN) && !full_q[rd_bank_q]) und_d = 1'b1;
      end
      // Emptying is applied after filling so that empty wins on a shared bank.
      if (rq_fall && svalid_q) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         svalid_d          = 1'b0;
      end

      // A burst still in flight keeps counting beats but its data is dropped.
      if (flush) begin
         full_d    = 2'b00;
         wr_bank_d = 1'b0;
         rd_bank_d = 1'b0;
         svalid_d  = 1'b0;
         fld_ok_d  = !drain_end;
         if (mem_req_q || (burst_act_q && !(MEM_DVAL_i && last_beat))) discard_d = 1'b1;
         if (field_start) begin
            field_line_d = 9'd0;
            fld_d        = FID_i;
            next_addr_d  = BASE_ADDR_i + (FID_i ? LB_A : '0);
         end
      end
   end

   // Register all control state; synchronous active-high reset.
   always_ff @(posedge CLK_i) begin
      if (RST) begin
         state_q      <= S_OFF;
         bt_en_q      <= 1'b0;
         pal_q        <= 1'b0;
         din_q        <= 8'h10;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         und_q        <= 1'b0;
         full_q       <= 2'b00;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         burst_act_q  <= 1'b0;
         discard_q    <= 1'b0;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         rq_q         <= 1'b0;
         svalid_q     <= 1'b0;
         field_line_q <= 9'd0;
         fld_q        <= 1'b0;
         fld_ok_q     <= 1'b0;
         next_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         bt_en_q      <= bt_en_d;
         pal_q        <= pal_d;
         din_q        <= din_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         und_q        <= und_d;
         full_q       <= full_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         burst_act_q  <= burst_act_d;
         discard_q    <= discard_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         rq_q         <= rq_d;
         svalid_q     <= svalid_d;
         field_line_q <= field_line_d;
         fld_q        <= fld_d;
         fld_ok_q     <= fld_ok_d;
         next_addr_q  <= next_addr_d;
      end
   end

   // Line buffer write port; contents need no reset since bank flags gate reads.
   always_ff @(posedge CLK_i) begin
      if (wr_en) buf_mem[wr_bank_q][wcnt_q] <= MEM_DATA_i;
   end

   assign BT_EN_o    = bt_en_q;
   assign PAL_o      = pal_q;
   assign DIN_o      = din_q;
   assign MEM_REQ_o  = mem_req_q;
   assign MEM_ADDR_o = mem_addr_q;
   assign UNDERRUN_o = und_q;

endmodule

// File: tb/tb_bt656_line_fetch_ctrl.sv
// Bench for bt656_line_fetch_ctrl: a short-line encoder stand-in, a memory model
// with 2-cycle grant latency, and a byte scoreboard on DIN_o.
module tb_bt656_line_fetch_ctrl;

   localparam int LB = 8;
   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          RST, EN_REQ_i, PAL_REQ_i, IM_END_i, DATA_RQ_i, FID_i;
   logic [AW-1:0] BASE_ADDR_i;
   logic [9:0]    LINE_CNT_i;
   logic [10:0]   PIX_CNT_i;
   logic          MEM_GNT_i, MEM_DVAL_i;
   logic [7:0]    MEM_DATA_i;
   logic          BT_EN_o, PAL_o, MEM_REQ_o, UNDERRUN_o;
   logic [7:0]    DIN_o;
   logic [AW-1:0] MEM_ADDR_o;

   bt656_line_fetch_ctrl #(.LINE_BYTES(LB), .MEM_AW(AW)) dut (
      .CLK_i(clk), .RST(RST), .EN_REQ_i(EN_REQ_i), .PAL_REQ_i(PAL_REQ_i),
      .BASE_ADDR_i(BASE_ADDR_i), .BT_EN_o(BT_EN_o), .PAL_o(PAL_o),
      .LINE_CNT_i(LINE_CNT_i), .PIX_CNT_i(PIX_CNT_i), .IM_END_i(IM_END_i),
      .DATA_RQ_i(DATA_RQ_i), .FID_i(FID_i), .DIN_o(DIN_o), .MEM_REQ_o(MEM_REQ_o),
      .MEM_ADDR_o(MEM_ADDR_o), .MEM_GNT_i(MEM_GNT_i), .MEM_DVAL_i(MEM_DVAL_i),
      .MEM_DATA_i(MEM_DATA_i), .UNDERRUN_o(UNDERRUN_o)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            failures = 0;
   logic [7:0]    exp_q[$];
   logic [AW-1:0] addr_log[$];
   int            gnt_cnt = 0;
   bit            starve = 1'b0;
   logic          rq_s = 1'b0;
   logic [7:0]    exp_b;
   logic [AW-1:0] ma;

   typedef struct {
      bit            pal;
      bit            fid;
      logic [AW-1:0] base;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
   } vec_t;
   vec_t tbl[4];

   function automatic logic [7:0] memf(input logic [AW-1:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      EN_REQ_i = 1'b0;
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      cyc();
   endtask

   task automatic start(input bit pal);
      EN_REQ_i  = 1'b1;
      PAL_REQ_i = pal;
      cyc();
   endtask

   task automatic field_start(input logic [9:0] ln, input bit fid, input int idle);
      LINE_CNT_i = ln;
      PIX_CNT_i  = 11'd0;
      FID_i      = fid;
      cyc();
      PIX_CNT_i = 11'd1;
      repeat (idle) cyc();
   endtask

   // One short active line; expected DIN bytes are queued as DATA_RQ is driven.
   task automatic line(input bit black, input logic [AW-1:0] a);
      LINE_CNT_i = 10'd500;
      PIX_CNT_i  = 11'd0;
      cyc();
      for (int p = 1; p < 5; p++) begin
         PIX_CNT_i = 11'(p);
         cyc();
      end
      for (int k = 0; k < LB; k++) begin
         PIX_CNT_i = 11'(5 + k);
         DATA_RQ_i = 1'b1;
         exp_q.push_back(black ? ((k % 2) ? 8'h10 : 8'h80) : memf(a + AW'(k)));
         cyc();
      end
      DATA_RQ_i = 1'b0;
      for (int j = 0; j < 4; j++) begin
         PIX_CNT_i = 11'(5 + LB + j);
         cyc();
      end
   endtask

   task automatic wait_dval(input int lim);
      int n;
      n = 0;
      while (MEM_DVAL_i !== 1'b1 && n < lim) begin
         cyc();
         n++;
      end
      check("dval_wait", {31'd0, MEM_DVAL_i}, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_bt_en"}, BT_EN_o, 0);
      check({tag, "_pal"}, PAL_o, 0);
      check({tag, "_din"}, DIN_o, 8'h10);
      check({tag, "_req"}, MEM_REQ_o, 0);
      check({tag, "_addr"}, MEM_ADDR_o, 0);
      check({tag, "_underrun"}, UNDERRUN_o, 0);
   endtask

   // Memory model: grant two cycles after a request, then LB consecutive beats.
   initial begin
      MEM_GNT_i = 1'b0; MEM_DVAL_i = 1'b0; MEM_DATA_i = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (MEM_REQ_o === 1'b1 && !starve) begin
            ma = MEM_ADDR_o;
            @(posedge clk); #1;
            MEM_GNT_i = 1'b1;
            addr_log.push_back(ma);
            gnt_cnt++;
            @(posedge clk); #1;
            MEM_GNT_i = 1'b0;
            for (int k = 0; k < LB; k++) begin
               MEM_DVAL_i = 1'b1;
               MEM_DATA_i = memf(ma + AW'(k));
               @(posedge clk); #1;
            end
            MEM_DVAL_i = 1'b0;
         end
      end
   end

   // Scoreboard: DIN_o reflects the DATA_RQ_i value seen at the previous edge.
   always @(posedge clk) rq_s <= DATA_RQ_i;
   always @(negedge clk) begin
      if (rq_s) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL din_unexpected actual=%0h required=none", DIN_o);
         end else begin
            exp_b = exp_q.pop_front();
            check("din_data", DIN_o, exp_b);
         end
      end else begin
         check("din_idle", DIN_o, 8'h10);
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{pal:1'b1, fid:1'b0, base:22'h001000, a0:22'h001000, a1:22'h001010};
      tbl[1] = '{pal:1'b1, fid:1'b1, base:22'h001000, a0:22'h001008, a1:22'h001018};
      tbl[2] = '{pal:1'b0, fid:1'b1, base:22'h002000, a0:22'h002008, a1:22'h002018};
      tbl[3] = '{pal:1'b1, fid:1'b0, base:22'h3FFFF8, a0:22'h3FFFF8, a1:22'h000008};

      RST = 1'b1; EN_REQ_i = 1'b0; PAL_REQ_i = 1'b0; BASE_ADDR_i = '0;
      LINE_CNT_i = 10'd0; PIX_CNT_i = 11'd1; IM_END_i = 1'b0; DATA_RQ_i = 1'b0; FID_i = 1'b0;
      cyc();
      cyc();
      check_reset_vals("reset");
      RST = 1'b0;
      cyc();

      // Field-start addressing, second fetch stride and address wrap.
      for (int i = 0; i < 4; i++) begin
         do_reset();
         addr_log.delete();
         BASE_ADDR_i = tbl[i].base;
         start(tbl[i].pal);
         check("bt_en_rise", BT_EN_o, 1);
         check("pal_load", PAL_o, tbl[i].pal);
         field_start(tbl[i].fid ? (tbl[i].pal ? 10'd334 : 10'd284) : 10'd21, tbl[i].fid, 40);
         check("prefetch_count", addr_log.size(), 2);
         check("addr0", (addr_log.size() > 0) ? addr_log[0] : '1, tbl[i].a0);
         check("addr1", (addr_log.size() > 1) ? addr_log[1] : '1, tbl[i].a1);
      end

      // PAL startup: streaming across both fields.
      do_reset();
      BASE_ADDR_i = 22'h021000;
      start(1'b1);
      field_start(10'd21, 1'b0, 40);
      for (int n = 0; n < 6; n++) line(1'b0, 22'h021000 + AW'(16 * n));
      field_start(10'd334, 1'b1, 40);
      for (int n = 0; n < 3; n++) line(1'b0, 22'h021008 + AW'(16 * n));
      check("startup_underrun", UNDERRUN_o, 0);

      // Starved memory: first line black, underrun sticky.
      do_reset();
      BASE_ADDR_i = 22'h005000;
      start(1'b1);
      starve = 1'b1;
      field_start(10'd21, 1'b0, 40);
      line(1'b1, '0);
      check("starve_underrun", UNDERRUN_o, 1);
      starve = 1'b0;
      repeat (40) cyc();
      line(1'b0, 22'h005000);
      check("starve_underrun_sticky", UNDERRUN_o, 1);

      // Format switch mid-frame, then a full NTSC field-1 fetch count.
      do_reset();
      BASE_ADDR_i = 22'h010000;
      start(1'b1);
      field_start(10'd21, 1'b0, 40);
      line(1'b0, 22'h010000);
      line(1'b0, 22'h010010);
      PAL_REQ_i = 1'b0;
      repeat (10) cyc();
      check("pal_held", PAL_o, 1);
      IM_END_i = 1'b1;
      cyc();
      IM_END_i = 1'b0;
      check("pal_switch", PAL_o, 0);
      gnt_cnt = 0;
      field_start(10'd21, 1'b0, 40);
      for (int n = 0; n < 243; n++) line(n >= 241, 22'h010000 + AW'(16 * n));
      check("ntsc_f1_fetches", gnt_cnt, 241);
      check("ntsc_past_limit_underrun", UNDERRUN_o, 1);

      // Disable mid-burst.
      do_reset();
      BASE_ADDR_i = 22'h008000;
      start(1'b1);
      gnt_cnt = 0;
      field_start(10'd21, 1'b0, 0);
      wait_dval(20);
      EN_REQ_i = 1'b0;
      repeat (30) cyc();
      check("drain_fetches", gnt_cnt, 1);
      check("drain_req", MEM_REQ_o, 0);
      check("drain_bt_en", BT_EN_o, 1);
      line(1'b1, '0);
      check("drain_underrun", UNDERRUN_o, 0);
      IM_END_i = 1'b1;
      cyc();
      IM_END_i = 1'b0;
      check("off_bt_en", BT_EN_o, 0);
      check("off_din", DIN_o, 8'h10);
      repeat (5) cyc();
      check("off_req", MEM_REQ_o, 0);

      // Reset during DVAL beats.
      do_reset();
      BASE_ADDR_i = 22'h00C000;
      start(1'b1);
      gnt_cnt = 0;
      field_start(10'd21, 1'b0, 0);
      wait_dval(20);
      cyc();
      cyc();
      EN_REQ_i = 1'b0;
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      check_reset_vals("midburst_reset");
      repeat (20) cyc();
      check("post_reset_req", MEM_REQ_o, 0);
      check("post_reset_fetches", gnt_cnt, 1);
      start(1'b1);
      field_start(10'd21, 1'b0, 40);
      line(1'b0, 22'h00C000);
      line(1'b0, 22'h00C010);

      repeat (3) cyc();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
